hq_sched: RTL and testbench

Scheduler/sequencer for the Hq = H·S complex multiply-accumulate datapath of the SOML decoder. It replaces the free-running address generator: on a start request it walks every (Si, rowH, colS) combination exactly once and drives the table/ROM address inputs with an issue strobe. It tags and captures the returned Hq_r/Hq_i values in a credit-controlled skid FIFO and presents them downstream on a valid/ready interface, then signals completion.

---
 rtl/hq_sched.sv | 238 +++++++++++++++++++++++
 tb/tb_hq_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hq_sched.sv
// hq_sched: address sequencer and result capture for the Hq = H*S complex MAC.
// On an accepted start it walks every (Si, rowH, colS) combination once, colS
// innermost, issuing one table/ROM address per cycle while credit allows.
// Each issue carries its tags down a PIPE_LAT-deep pipeline. The returning
// datapath result is captured with those tags in a small FIFO and streamed out
// on a valid/ready port. done pulses once everything has been popped.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-low reset
//   start, num_s_m1               job request (IDLE only), last Si index
//   busy, done                    job in progress, one-cycle completion pulse
//   issue, addr_Si/rowH/colS      address strobe and table/ROM address
//   hq_r_in, hq_i_in              Q8.8 result, PIPE_LAT cycles after issue
//   out_valid, out_ready          result handshake
//   out_r, out_i                  result value
//   out_si, out_row, out_col      result tags
//   out_last                      final result of the job
//   eng_valid, eng_data           per-Si energy (tied to 0 unless enabled)
//
// Build option: define HQ_SCHED_ENERGY_EN to add the per-Si energy accumulator.
//
// state    | meaning
// IDLE     | waiting for start
// RUN      | issuing addresses, throttled by FIFO credit
// DRAIN    | all issued, waiting for pipeline and FIFO to empty
// DONE     | one-cycle done pulse
module hq_sched #(
   parameter int PIPE_LAT   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  num_s_m1,
   output logic        busy,
   output logic        done,
   output logic        issue,
   output logic [3:0]  addr_Si,
   output logic [1:0]  addr_rowH,
   output logic [1:0]  addr_colS,
   input  logic [15:0] hq_r_in,
   input  logic [15:0] hq_i_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_r,
   output logic [15:0] out_i,
   output logic [3:0]  out_si,
   output logic [1:0]  out_row,
   output logic [1:0]  out_col,
   output logic        out_last,
   output logic        eng_valid,
   output logic [31:0] eng_data
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = 9;            // {si, row, col, last}
   localparam int EW = 32 + TW;      // {r, i, tag}

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [3:0]          num_q, num_d, si_q, si_d;
   logic [1:0]          row_q, row_d, col_q, col_d;
   logic [PIPE_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [TW-1:0]       pipe_tag_q [PIPE_LAT];
   logic [TW-1:0]       pipe_tag_d [PIPE_LAT];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [EW-1:0]       mem_q [FIFO_DEPTH];
   logic [EW-1:0]       head;
   logic [7:0]          in_flight;
   logic                credit_ok, last_addr, push, pop;
   logic [TW-1:0]       push_tag;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      in_flight = '0;
      for (int k = 0; k < PIPE_LAT; k++) in_flight = in_flight + {7'd0, pipe_vld_q[k]};
   end

   // Credit covers both in-flight results and queued ones, so a push can never hit a full FIFO.
   assign credit_ok = (in_flight + 8'(count_q)) < 8'(FIFO_DEPTH);
   assign issue     = (state_q == ST_RUN) && credit_ok;
   assign last_addr = (si_q == num_q) && (row_q == 2'd3) && (col_q == 2'd3);
   assign push      = pipe_vld_q[PIPE_LAT-1];
   assign push_tag  = pipe_tag_q[PIPE_LAT-1];
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      si_d    = si_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               num_d   = num_s_m1;
               si_d    = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_RUN: begin
            if (issue) begin
               // The final address is left on the bus rather than wrapping.
               if (last_addr) begin
                  state_d = ST_DRAIN;
               end else begin
                  col_d = col_q + 2'd1;
                  if (col_q == 2'd3) row_d = row_q + 2'd1;
                  if ((col_q == 2'd3) && (row_q == 2'd3)) si_d = si_q + 4'd1;
               end
            end
         end
         ST_DRAIN: begin
            if ((in_flight == '0) && (count_q == '0)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pipe_vld_d    = pipe_vld_q;
      pipe_tag_d    = pipe_tag_q;
      pipe_vld_d[0] = issue;
      pipe_tag_d[0] = {si_q, row_q, col_q, last_addr};
      for (int k = 1; k < PIPE_LAT; k++) begin
         pipe_vld_d[k] = pipe_vld_q[k-1];
         pipe_tag_d[k] = pipe_tag_q[k-1];
      end
   end

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         si_q       <= '0;
         row_q      <= '0;
         col_q      <= '0;
         pipe_vld_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         si_q       <= si_d;
         row_q      <= row_d;
         col_q      <= col_d;
         pipe_vld_q <= pipe_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Tags and FIFO storage are qualified by pipe_vld_q / count_q, so no reset needed.
   always_ff @(posedge clk) begin
      pipe_tag_q <= pipe_tag_d;
      if (push) mem_q[wr_ptr_q] <= {hq_r_in, hq_i_in, push_tag};
   end

   assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_r     = head[40:25];
   assign out_i     = head[24:9];
   assign out_si    = head[8:5];
   assign out_row   = head[4:3];
   assign out_col   = head[2:1];
   assign out_last  = head[0];
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign addr_Si   = si_q;
   assign addr_rowH = row_q;
   assign addr_colS = col_q;

`ifdef HQ_SCHED_ENERGY_EN
   logic signed [31:0] r_ext, i_ext, sq_r, sq_i;
   logic [33:0]        acc_sum;
   logic [31:0]        acc_sat, acc_q, acc_d, eng_data_q, eng_data_d;
   logic               eng_valid_q, eng_valid_d;

   always_comb begin
      r_ext       = 32'(signed'(hq_r_in));
      i_ext       = 32'(signed'(hq_i_in));
      // Each square is at most 2^30, so the low 32 bits are the exact product.
      sq_r        = r_ext * r_ext;
      sq_i        = i_ext * i_ext;
      acc_sum     = {2'b00, acc_q} + {2'b00, sq_r} + {2'b00, sq_i};
      acc_sat     = (acc_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : acc_sum[31:0];
      acc_d       = acc_q;
      eng_valid_d = 1'b0;
      eng_data_d  = eng_data_q;
      if (push) begin
         if (push_tag[4:1] == 4'hF) begin
            eng_valid_d = 1'b1;
            eng_data_d  = acc_sat;
            acc_d       = '0;
         end else begin
            acc_d = acc_sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q       <= '0;
         eng_valid_q <= 1'b0;
         eng_data_q  <= '0;
      end else begin
         acc_q       <= acc_d;
         eng_valid_q <= eng_valid_d;
         eng_data_q  <= eng_data_d;
      end
   end

   assign eng_valid = eng_valid_q;
   assign eng_data  = eng_data_q;
`else
   assign eng_valid = 1'b0;
   assign eng_data  = 32'd0;
`endif

endmodule

// File: tb/tb_hq_sched.sv
module tb_hq_sched;
   localparam int PIPE_LAT   = 2;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, issue, out_valid, out_ready, out_last, eng_valid;
   logic [3:0]  num_s_m1, addr_Si, out_si;
   logic [1:0]  addr_rowH, addr_colS, out_row, out_col;
   logic [15:0] hq_r_in, hq_i_in, out_r, out_i;
   logic [31:0] eng_data;

   hq_sched #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .num_s_m1(num_s_m1),
      .busy(busy), .done(done), .issue(issue),
      .addr_Si(addr_Si), .addr_rowH(addr_rowH), .addr_colS(addr_colS),
      .hq_r_in(hq_r_in), .hq_i_in(hq_i_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .out_si(out_si), .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .eng_valid(eng_valid), .eng_data(eng_data)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int cyc = 0, done_cnt = 0, job_issues = 0;
   int first_issue_cyc = 0, fifth_issue_cyc = 0, last_issue_cyc = 0, done_cyc = 0, start_cyc = 0;
   logic [7:0]  exp_issue [$];
   logic [40:0] exp_out [$];
   logic [31:0] exp_eng [$];
   logic [7:0]  mon_iss;
   logic [40:0] mon_out;
   logic [31:0] mon_eng;
   bit          const_mode;
   logic [15:0] const_r, const_i;
   logic [15:0] d1_r, d1_i, d2_r, d2_i;

   function automatic logic [15:0] data_r(input logic [3:0] s, input logic [1:0] r, input logic [1:0] c);
      return const_mode ? const_r : {4'h1, s, r, c, 4'h0};
   endfunction

   function automatic logic [15:0] data_i(input logic [3:0] s, input logic [1:0] r, input logic [1:0] c);
      return const_mode ? const_i : {4'hC, c, r, s, 4'h3};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Table/ROM + complex multiplier: result appears PIPE_LAT cycles after the address.
   always @(posedge clk) begin
      d1_r <= data_r(addr_Si, addr_rowH, addr_colS);
      d1_i <= data_i(addr_Si, addr_rowH, addr_colS);
      d2_r <= d1_r;
      d2_i <= d1_i;
   end
   assign hq_r_in = d2_r;
   assign hq_i_in = d2_i;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (issue) begin
         job_issues++;
         last_issue_cyc = cyc;
         if (job_issues == 1) first_issue_cyc = cyc;
         if (job_issues == 5) fifth_issue_cyc = cyc;
         check("issue_expected", 64'(exp_issue.size() != 0), 64'(1));
         if (exp_issue.size() != 0) begin
            mon_iss = exp_issue.pop_front();
            check("issue_addr", 64'({addr_Si, addr_rowH, addr_colS}), 64'(mon_iss));
         end
      end
      if (out_valid && out_ready) begin
         check("out_expected", 64'(exp_out.size() != 0), 64'(1));
         if (exp_out.size() != 0) begin
            mon_out = exp_out.pop_front();
            check("out_word", 64'({out_r, out_i, out_si, out_row, out_col, out_last}), 64'(mon_out));
         end
      end
      if (eng_valid) begin
         check("eng_expected", 64'(exp_eng.size() != 0), 64'(1));
         if (exp_eng.size() != 0) begin
            mon_eng = exp_eng.pop_front();
            check("eng_data", 64'(eng_data), 64'(mon_eng));
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!rst) begin
         exp_issue.delete();
         exp_out.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_job(input logic [3:0] n);
      for (int s = 0; s <= int'(n); s++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               exp_issue.push_back({4'(s), 2'(r), 2'(c)});
               exp_out.push_back({data_r(4'(s), 2'(r), 2'(c)), data_i(4'(s), 2'(r), 2'(c)),
                                  4'(s), 2'(r), 2'(c), (s == int'(n)) && (r == 3) && (c == 3)});
            end
   endtask

   task automatic start_job(input logic [3:0] n);
      expect_job(n);
      job_issues = 0;
      num_s_m1   = n;
      start      = 1'b1;
      start_cyc  = cyc;
      tick();
      start    = 1'b0;
      num_s_m1 = 4'hA;
   endtask

   task automatic wait_done(input int budget);
      int  d0;
      bit  got;
      d0  = done_cnt;
      got = 1'b0;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", 64'(got), 64'(1));
      check("busy_after_done", 64'(busy), 64'(0));
      repeat (3) tick();
      check("done_once", 64'(done_cnt - d0), 64'(1));
      check("issue_queue_empty", 64'(exp_issue.size()), 64'(0));
      check("out_queue_empty", 64'(exp_out.size()), 64'(0));
   endtask

   initial begin
      int d0;
      rst        = 1'b0;
      start      = 1'b1;
      num_s_m1   = 4'h5;
      out_ready  = 1'b1;
      const_mode = 1'b1;
      const_r    = 16'h0100;
      const_i    = 16'hFF00;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_issue", 64'(issue), 64'(0));
      check("rst_addr", 64'({addr_Si, addr_rowH, addr_colS}), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'({out_r, out_i}), 64'(0));
      check("rst_out_tags", 64'({out_si, out_row, out_col, out_last}), 64'(0));
      check("rst_eng", 64'({eng_valid, eng_data}), 64'(0));
      rst   = 1'b1;
      start = 1'b0;
      tick();
      check("idle_issue", 64'(issue), 64'(0));

      // single Si, constant data, ready held high
      start_job(4'd0);
      check("busy_after_start", 64'(busy), 64'(1));
      wait_done(200);
      check("first_issue_lat", 64'(first_issue_cyc - start_cyc), 64'(1));
      check("done_lat", 64'(done_cyc - last_issue_cyc), 64'(PIPE_LAT + 3));
      check("single_issues", 64'(job_issues), 64'(16));

      // backpressure: ready low for 20 cycles
      const_mode = 1'b0;
      out_ready  = 1'b0;
      start_job(4'd1);
      repeat (19) tick();
      check("stall_issues", 64'(job_issues), 64'(FIFO_DEPTH));
      check("stall_out_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      d0 = cyc;
      wait_done(300);
      check("resume_cycle", 64'(fifth_issue_cyc - d0), 64'(1));
      check("bp_issues", 64'(job_issues), 64'(32));

      // start pulsed during RUN is ignored
      start_job(4'd2);
      repeat (5) tick();
      num_s_m1 = 4'h3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      wait_done(300);
      check("midstart_issues", 64'(job_issues), 64'(48));

      // reset in RUN after 5 issues
      d0 = done_cnt;
      start_job(4'd1);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_issue", 64'(issue), 64'(0));
      repeat (10) tick();
      check("midrst_issues", 64'(job_issues), 64'(5));
      check("midrst_no_done", 64'(done_cnt - d0), 64'(0));
      start_job(4'd0);
      wait_done(200);
      check("post_rst_issues", 64'(job_issues), 64'(16));

`ifdef HQ_SCHED_ENERGY_EN
      const_mode = 1'b1;
      const_r    = 16'h0100;
      const_i    = 16'h0000;
      exp_eng.push_back(32'h0010_0000);
      exp_eng.push_back(32'h0010_0000);
      start_job(4'd1);
      wait_done(200);
      check("eng_pulses", 64'(exp_eng.size()), 64'(0));
      const_r = 16'h8000;
      const_i = 16'h8000;
      exp_eng.push_back(32'hFFFF_FFFF);
      start_job(4'd0);
      wait_done(200);
      check("eng_sat_pulses", 64'(exp_eng.size()), 64'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

endmodule
